clint_timer: RTL

//  Core-local interrupt source; the far end of the core's trap-input interface.
//  - Memory-mapped Wishbone slave holding a 64-bit MTIME counter, a 64-bit MTIMECMP and an MSIP bit.
//  - Drives timer_irq_o into the core's intrpt_timer_i and soft_irq_o into intrpt_soft_i.
//  - Gating, pending capture and mcause are handled on the core side, not here.

---
 rtl/clint_timer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// clint_timer: core-local interrupt source with a Wishbone register slave.
// Holds a 64-bit MTIME counter, a 64-bit MTIMECMP and the MSIP bit; drives
// timer_irq_o (MTIME >= MTIMECMP, registered) and soft_irq_o (MSIP[0]).
// Optional feature macro: TIMER_PRESCALE_EN -- when defined, MTIME advances
// once every PRESCALE clk_i cycles via a 16-bit prescale counter; when
// undefined MTIME advances every cycle and PRESCALE is ignored.
module clint_timer #(
    parameter logic [15:0] PRESCALE = 16'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        timer_irq_o,
    output logic        soft_irq_o
);

    typedef enum logic [2:0] {
        ADR_MTIME_LO    = 3'd0,
        ADR_MTIME_HI    = 3'd1,
        ADR_MTIMECMP_LO = 3'd2,
        ADR_MTIMECMP_HI = 3'd3,
        ADR_MSIP        = 3'd4
    } reg_adr_e;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        timer_irq_q, timer_irq_d;

    logic        tick;
    logic        accept;
    logic        wr;
    logic [31:0] rdata;

    // Byte-lane merge: selected bytes come from the bus, others keep old value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

`ifdef TIMER_PRESCALE_EN
    // A PRESCALE of 0 behaves like 1 (counter pinned at 0, tick every cycle).
    localparam logic [15:0] PRESC_LAST = (PRESCALE == 16'd0) ? 16'd0 : PRESCALE - 16'd1;

    logic [15:0] presc_q, presc_d;

    // Prescale counter: counts 0..PRESC_LAST, MTIME ticks on the wrap to 0.
    always_comb begin
        tick    = (presc_q >= PRESC_LAST);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    // Prescale counter register; unaffected by MTIME writes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) presc_q <= '0;
        else        presc_q <= presc_d;
    end
`else
    assign tick = 1'b1;
`endif

    // Bus decode, register update and read mux.
    always_comb begin
        accept = wb_cyc_i & wb_stb_i & ~ack_q;
        wr     = accept & wb_we_i;

        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        // A write to either MTIME word overrides the increment for that cycle;
        // the other word holds its pre-edge value.
        if (wr) begin
            case (wb_adr_i)
                ADR_MTIME_LO:    mtime_d    = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
                ADR_MTIME_HI:    mtime_d    = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
                ADR_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i)};
                ADR_MTIMECMP_HI: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i), mtimecmp_q[31:0]};
                ADR_MSIP:        if (wb_sel_i[0]) msip_d = wb_dat_i[0];
                default:         ;
            endcase
        end

        case (wb_adr_i)
            ADR_MTIME_LO:    rdata = mtime_q[31:0];
            ADR_MTIME_HI:    rdata = mtime_q[63:32];
            ADR_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            ADR_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            ADR_MSIP:        rdata = {31'd0, msip_q};
            default:         rdata = '0;
        endcase

        ack_d       = accept;
        dat_d       = (accept & ~wb_we_i) ? rdata : '0;
        timer_irq_d = (mtime_q >= mtimecmp_q);
    end

    // State and registered outputs; asynchronous reset discards a pending ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            timer_irq_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign timer_irq_o = timer_irq_q;
    assign soft_irq_o  = msip_q;

endmodule
